// File: rtl/rtc_bus_master.sv
// rtc_bus_master: master for the external RTC multiplexed address/data bus.
// Runs single user write/read transactions on request, otherwise auto-scans
// the time/date registers and streams each byte to the graphics path.
//
// Ports
//   reloj, resetM                 clock, asynchronous active-high reset
//   req, req_wr, req_addr,        user transaction request (sampled in IDLE)
//   req_data
//   scan_en                       allow auto-scan reads when no request
//   busy, done                    transaction in flight / user txn complete
//   rd_data                       last byte read
//   DIR_DATO, POSICION, READ      byte, scan index (F = user) and update strobe
//   ad_out, ad_oe, ad_in          pad drive value, pad enable, pad sample
//   CS_n, RD_n, WR_n, A_D         RTC control (A_D 0 = address, 1 = data)
module rtc_bus_master #(
    parameter int unsigned T_PHASE   = 4,
    parameter int unsigned T_GAP     = 2,
    parameter int unsigned N_SCAN    = 9,
    parameter logic [7:0]  SCAN_BASE = 8'h21
) (
    input  logic       reloj,
    input  logic       resetM,
    input  logic       req,
    input  logic       req_wr,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_data,
    input  logic       scan_en,
    output logic       busy,
    output logic       done,
    output logic [7:0] rd_data,
    output logic [7:0] DIR_DATO,
    output logic [3:0] POSICION,
    output logic       READ,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic [7:0] ad_in,
    output logic       CS_n,
    output logic       RD_n,
    output logic       WR_n,
    output logic       A_D
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_PHASE = CNT_W'(T_PHASE);
    localparam logic [CNT_W-1:0] CNT_GAP   = CNT_W'(T_GAP);
    localparam logic [3:0]       IDX_LAST  = 4'(N_SCAN - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR_ST  = 3'd1,
        ADDR_GAP = 3'd2,
        DATA_ST  = 3'd3,
        DATA_GAP = 3'd4
    } state_t;

    // Captured transaction: direction, address, write data and origin.
    typedef struct packed {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
        logic       scan;
    } txn_t;

    state_t           state;
    txn_t             txn;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       scan_idx;
    logic [7:0]       rx_byte;
    logic [7:0]       start_addr_c;
    logic             start_c;

    // User request has priority over the scan for the next transaction.
    always_comb begin
        start_c      = req | scan_en;
        start_addr_c = req ? req_addr : (SCAN_BASE + {4'h0, scan_idx});
    end

    // Transaction sequencer; every bus/control output is registered here.
    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            state    <= IDLE;
            txn      <= '0;
            cnt      <= '0;
            scan_idx <= '0;
            rx_byte  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            READ     <= 1'b0;
            rd_data  <= '0;
            DIR_DATO <= '0;
            POSICION <= '0;
            ad_out   <= '0;
            ad_oe    <= 1'b0;
            CS_n     <= 1'b1;
            RD_n     <= 1'b1;
            WR_n     <= 1'b1;
            A_D      <= 1'b1;
        end else begin
            done <= 1'b0;
            READ <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_c) begin
                        txn.wr   <= req & req_wr;
                        txn.addr <= start_addr_c;
                        txn.data <= req_data;
                        txn.scan <= ~req;
                        state    <= ADDR_ST;
                        cnt      <= CNT_PHASE;
                        busy     <= 1'b1;
                        CS_n     <= 1'b0;
                        WR_n     <= 1'b0;
                        A_D      <= 1'b0;
                        ad_oe    <= 1'b1;
                        ad_out   <= start_addr_c;
                    end
                end
                ADDR_ST: begin
                    if (cnt == CNT_W'(1)) begin
                        // Address stays driven through the gap as hold time.
                        state <= ADDR_GAP;
                        cnt   <= CNT_GAP;
                        CS_n  <= 1'b1;
                        WR_n  <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ADDR_GAP: begin
                    if (cnt == CNT_W'(1)) begin
                        state <= DATA_ST;
                        cnt   <= CNT_PHASE;
                        CS_n  <= 1'b0;
                        A_D   <= 1'b1;
                        if (txn.wr) begin
                            WR_n   <= 1'b0;
                            ad_oe  <= 1'b1;
                            ad_out <= txn.data;
                        end else begin
                            RD_n  <= 1'b0;
                            ad_oe <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DATA_ST: begin
                    if (cnt == CNT_W'(1)) begin
                        // Sample on the last strobe clock, before RD_n rises.
                        if (!txn.wr) begin
                            rx_byte <= ad_in;
                        end
                        state <= DATA_GAP;
                        cnt   <= CNT_GAP;
                        CS_n  <= 1'b1;
                        RD_n  <= 1'b1;
                        WR_n  <= 1'b1;
                        ad_oe <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DATA_GAP: begin
                    if (cnt == CNT_W'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= ~txn.scan;
                        if (!txn.wr) begin
                            rd_data  <= rx_byte;
                            DIR_DATO <= rx_byte;
                            POSICION <= txn.scan ? scan_idx : 4'hF;
                            READ     <= 1'b1;
                        end
                        if (txn.scan) begin
                            scan_idx <= (scan_idx == IDX_LAST) ? 4'h0 : scan_idx + 4'h1;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Bus safety: never read and write strobes together, never drive during a read.
    a_no_dual_strobe: assert property (@(posedge reloj) disable iff (resetM) !(!RD_n && !WR_n));
    a_no_drive_on_read: assert property (@(posedge reloj) disable iff (resetM) !(ad_oe && !RD_n));

endmodule
